// File: rtl/lza_chunk_sched.sv
// Chunked LZA detection scheduler: streams a wide n/z/p indicator string through a
// shared narrow detection tree, MSB chunk first, folding the per-chunk flags into full-width flags.
module lza_chunk_sched #(
   parameter int DATA_WIDTH  = 32,
   parameter int CHUNK_WIDTH = 8,
   localparam int NUM_CHUNKS = DATA_WIDTH / CHUNK_WIDTH,
   localparam int IDX_W      = (NUM_CHUNKS > 1) ? $clog2(NUM_CHUNKS) : 1
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   in_valid,
   output logic                   in_ready,
   input  logic [DATA_WIDTH-1:0]  in_n,
   input  logic [DATA_WIDTH-1:0]  in_z,
   input  logic [DATA_WIDTH-1:0]  in_p,
   output logic [CHUNK_WIDTH-1:0] dt_n,
   output logic [CHUNK_WIDTH-1:0] dt_z,
   output logic [CHUNK_WIDTH-1:0] dt_p,
   input  logic                   dt_Z,
   input  logic                   dt_N,
   input  logic                   dt_P,
   input  logic                   dt_Y,
   output logic                   dt_active,
   output logic                   out_valid,
   input  logic                   out_ready,
   output logic                   out_Z,
   output logic                   out_N,
   output logic                   out_P,
   output logic                   out_Y,
   output logic [IDX_W-1:0]       out_first_nz
);

   typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

   state_t                  state_q, state_d;
   logic [DATA_WIDTH-1:0]   n_sh_q, n_sh_d, z_sh_q, z_sh_d, p_sh_q, p_sh_d;
   logic [IDX_W-1:0]        cnt_q, cnt_d, first_nz_q, first_nz_d;
   logic                    acc_z_q, acc_z_d, acc_n_q, acc_n_d;
   logic                    acc_p_q, acc_p_d, acc_y_q, acc_y_d;
   logic                    last_chunk;

   assign last_chunk = (cnt_q == IDX_W'(NUM_CHUNKS - 1));

   // state register
   always_ff @(posedge clk or posedge rst) begin
      if (rst) state_q <= S_IDLE;
      else     state_q <= state_d;
   end

   // next-state logic
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         S_IDLE: if (in_valid)   state_d = S_RUN;
         S_RUN:  if (last_chunk) state_d = S_DONE;
         S_DONE: if (out_ready)  state_d = S_IDLE;
         default:                state_d = S_IDLE;
      endcase
   end

   // outputs: the tree port is driven only while RUN owns it
   always_comb begin
      in_ready  = (state_q == S_IDLE);
      out_valid = (state_q == S_DONE);
      dt_active = (state_q == S_RUN);
      dt_n      = '0;
      dt_z      = '0;
      dt_p      = '0;
      if (state_q == S_RUN) begin
         dt_n = n_sh_q[DATA_WIDTH-1 -: CHUNK_WIDTH];
         dt_z = z_sh_q[DATA_WIDTH-1 -: CHUNK_WIDTH];
         dt_p = p_sh_q[DATA_WIDTH-1 -: CHUNK_WIDTH];
      end
   end

   assign out_Z        = acc_z_q;
   assign out_N        = acc_n_q;
   assign out_P        = acc_p_q;
   assign out_Y        = acc_y_q;
   assign out_first_nz = first_nz_q;

   always_comb begin
      n_sh_d     = n_sh_q;
      z_sh_d     = z_sh_q;
      p_sh_d     = p_sh_q;
      cnt_d      = cnt_q;
      first_nz_d = first_nz_q;
      acc_z_d    = acc_z_q;
      acc_n_d    = acc_n_q;
      acc_p_d    = acc_p_q;
      acc_y_d    = acc_y_q;
      if (state_q == S_IDLE && in_valid) begin
         n_sh_d     = in_n;
         z_sh_d     = in_z;
         p_sh_d     = in_p;
         cnt_d      = '0;
         first_nz_d = '0;
         acc_z_d    = 1'b1;
         acc_n_d    = 1'b0;
         acc_p_d    = 1'b0;
         acc_y_d    = 1'b0;
      end else if (state_q == S_RUN) begin
         // accumulator is the high (earlier) half, tree response the low half
         acc_z_d = acc_z_q & dt_Z;
         acc_n_d = (acc_z_q & dt_N) | (acc_n_q & dt_Z);
         acc_p_d = acc_p_q | (acc_z_q & dt_P);
         acc_y_d = acc_y_q | (acc_z_q & dt_Y) | (acc_n_q & dt_P);
         if (acc_z_q && !dt_Z) first_nz_d = cnt_q;
         n_sh_d = n_sh_q << CHUNK_WIDTH;
         z_sh_d = z_sh_q << CHUNK_WIDTH;
         p_sh_d = p_sh_q << CHUNK_WIDTH;
         cnt_d  = cnt_q + IDX_W'(1);
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         n_sh_q     <= '0;
         z_sh_q     <= '0;
         p_sh_q     <= '0;
         cnt_q      <= '0;
         first_nz_q <= '0;
         acc_z_q    <= 1'b0;
         acc_n_q    <= 1'b0;
         acc_p_q    <= 1'b0;
         acc_y_q    <= 1'b0;
      end else begin
         n_sh_q     <= n_sh_d;
         z_sh_q     <= z_sh_d;
         p_sh_q     <= p_sh_d;
         cnt_q      <= cnt_d;
         first_nz_q <= first_nz_d;
         acc_z_q    <= acc_z_d;
         acc_n_q    <= acc_n_d;
         acc_p_q    <= acc_p_d;
         acc_y_q    <= acc_y_d;
      end
   end

endmodule

// File: tb/tb_lza_chunk_sched.sv
// Bench for lza_chunk_sched: an 8-wide detection tree model hangs off the dt_* port,
// results are checked against table constants through a scoreboard queue.
module tb_lza_chunk_sched;
   localparam int DW = 32;
   localparam int CW = 8;

   logic clk = 1'b0, rst = 1'b1;
   logic in_valid = 1'b0, in_ready, out_valid, out_ready = 1'b1;
   logic [DW-1:0] in_n = '0, in_z = '0, in_p = '0;
   logic [CW-1:0] dt_n, dt_z, dt_p;
   logic dt_Z, dt_N, dt_P, dt_Y, dt_active;
   logic out_Z, out_N, out_P, out_Y;
   logic [1:0] out_first_nz;

   lza_chunk_sched #(.DATA_WIDTH(DW), .CHUNK_WIDTH(CW)) dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
      .in_n(in_n), .in_z(in_z), .in_p(in_p),
      .dt_n(dt_n), .dt_z(dt_z), .dt_p(dt_p),
      .dt_Z(dt_Z), .dt_N(dt_N), .dt_P(dt_P), .dt_Y(dt_Y), .dt_active(dt_active),
      .out_valid(out_valid), .out_ready(out_ready),
      .out_Z(out_Z), .out_N(out_N), .out_P(out_P), .out_Y(out_Y),
      .out_first_nz(out_first_nz));

   always #5 clk = ~clk;

   // pairwise detection tree, element 0 is the MSB position
   function automatic logic [3:0] tree(input logic [CW-1:0] n, input logic [CW-1:0] z,
                                       input logic [CW-1:0] p);
      logic zz[CW], nn[CW], pp[CW], yy[CW];
      int w;
      for (int i = 0; i < CW; i++) begin
         zz[i] = z[CW-1-i]; nn[i] = n[CW-1-i]; pp[i] = p[CW-1-i]; yy[i] = 1'b0;
      end
      w = CW;
      while (w > 1) begin
         for (int i = 0; i < w/2; i++) begin
            logic zh, nh, ph, yh, zl, nl, pl, yl;
            zh = zz[2*i];   nh = nn[2*i];   ph = pp[2*i];   yh = yy[2*i];
            zl = zz[2*i+1]; nl = nn[2*i+1]; pl = pp[2*i+1]; yl = yy[2*i+1];
            zz[i] = zh & zl;
            nn[i] = (zh & nl) | (nh & zl);
            pp[i] = ph | (zh & pl);
            yy[i] = yh | (zh & yl) | (nh & pl);
         end
         w = w / 2;
      end
      return {zz[0], nn[0], pp[0], yy[0]};
   endfunction

   logic [3:0] tree_out;
   assign tree_out = tree(dt_n, dt_z, dt_p);
   assign {dt_Z, dt_N, dt_P, dt_Y} = tree_out;

   typedef struct {
      logic [DW-1:0] n, z, p;
      logic [3:0]    zpny;   // expected {Z,N,P,Y}
      logic [1:0]    fnz;
   } vec_t;

   typedef struct {
      logic [3:0] zpny;
      logic [1:0] fnz;
   } exp_t;

   vec_t vecs[8];
   exp_t sb[$];
   int   total = 0, bad = 0;
   int   cyc = 0;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // scoreboard: one pop per result handshake
   always @(negedge clk) begin
      if (!rst && out_valid && out_ready) begin
         if (sb.size() == 0) begin
            chk("unexpected_result", 32'd1, 32'd0);
         end else begin
            exp_t e;
            e = sb.pop_front();
            chk("flags_ZNPY", {28'd0, out_Z, out_N, out_P, out_Y}, {28'd0, e.zpny});
            chk("first_nz", {30'd0, out_first_nz}, {30'd0, e.fnz});
         end
      end
   end

   // drive one request; returns the cycle index in which it was accepted
   task automatic accept(input vec_t v, input bit push, output int acc_cyc);
      int k;
      k = 0;
      @(negedge clk);
      while (!in_ready && k < 50) begin @(negedge clk); k++; end
      if (!in_ready) chk("in_ready_timeout", 32'd0, 32'd1);
      @(posedge clk); #1;
      in_valid = 1'b1; in_n = v.n; in_z = v.z; in_p = v.p;
      @(negedge clk);
      acc_cyc = cyc;
      @(posedge clk);
      if (push) sb.push_back('{zpny: v.zpny, fnz: v.fnz});
      #1 in_valid = 1'b0;
   endtask

   // wait for out_valid; reports latency in cycles and dt_active cycle count
   task automatic wait_result(input int acc_cyc, output int lat, output int act_cnt);
      int k;
      act_cnt = 0; lat = -1; k = 0;
      while (k < 40) begin
         @(negedge clk);
         if (dt_active) act_cnt++;
         if (out_valid) begin lat = cyc - acc_cyc; break; end
         k++;
      end
      if (lat < 0) chk("out_valid_timeout", 32'd0, 32'd1);
   endtask

   initial begin
      int a, lat, ac;
      vecs[0] = '{32'h0,        32'hFFFFFFFF, 32'h0,        4'b1000, 2'd0};
      vecs[1] = '{32'h00008000, 32'hFFFF7FFF, 32'h0,        4'b0100, 2'd2};
      vecs[2] = '{32'h0,        32'h7FFFFFFF, 32'h80000000, 4'b0010, 2'd0};
      vecs[3] = '{32'h01000000, 32'hFE7FFFFF, 32'h00800000, 4'b0001, 2'd0};
      vecs[4] = '{32'h80000000, 32'h3FFFFFFF, 32'h40000000, 4'b0001, 2'd0};
      vecs[5] = '{32'h0,        32'hFFFFFFFE, 32'h00000001, 4'b0010, 2'd3};
      vecs[6] = '{32'hFFFFFFFF, 32'h0,        32'h0,        4'b0000, 2'd0};
      vecs[7] = '{32'h00800000, 32'hFF7FFF7F, 32'h00000080, 4'b0001, 2'd1};

      // reset values, sampled while rst is high
      #12;
      chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
      chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
      chk("rst_dt_active", {31'd0, dt_active}, 32'd0);
      chk("rst_flags", {28'd0, out_Z, out_N, out_P, out_Y}, 32'd0);
      chk("rst_first_nz", {30'd0, out_first_nz}, 32'd0);
      @(posedge clk); #1 rst = 1'b0;

      // table-driven vectors, with latency and tree occupancy checks on each
      for (int i = 0; i < 8; i++) begin
         accept(vecs[i], 1'b1, a);
         wait_result(a, lat, ac);
         chk($sformatf("latency_v%0d", i), lat, 32'd5);
         chk($sformatf("dt_active_cycles_v%0d", i), ac, 32'd4);
         @(negedge clk);
      end

      // hold a result with out_ready low while in_valid pulses
      out_ready = 1'b0;
      accept(vecs[1], 1'b1, a);
      wait_result(a, lat, ac);
      for (int i = 0; i < 3; i++) begin
         @(posedge clk); #1;
         in_valid = 1'b1; in_n = vecs[2].n; in_z = vecs[2].z; in_p = vecs[2].p;
         @(negedge clk);
         chk("hold_out_valid", {31'd0, out_valid}, 32'd1);
         chk("hold_in_ready", {31'd0, in_ready}, 32'd0);
         chk("hold_flags", {28'd0, out_Z, out_N, out_P, out_Y}, 32'b0100);
         chk("hold_first_nz", {30'd0, out_first_nz}, 32'd2);
      end
      @(posedge clk); #1;
      in_valid = 1'b0; out_ready = 1'b1;
      @(negedge clk);
      @(negedge clk);
      chk("release_in_ready", {31'd0, in_ready}, 32'd1);
      chk("release_out_valid", {31'd0, out_valid}, 32'd0);
      accept(vecs[2], 1'b1, a);
      wait_result(a, lat, ac);
      @(negedge clk);

      // reset mid-operation: result discarded
      accept(vecs[1], 1'b0, a);
      @(negedge clk); @(negedge clk);
      chk("pre_rst_dt_active", {31'd0, dt_active}, 32'd1);
      #1 rst = 1'b1;
      #1;
      chk("midrst_in_ready", {31'd0, in_ready}, 32'd1);
      chk("midrst_dt_active", {31'd0, dt_active}, 32'd0);
      chk("midrst_dt_bus", {8'd0, dt_n, dt_z, dt_p}, 32'd0);
      chk("midrst_outs", {26'd0, out_valid, out_Z, out_N, out_P, out_Y, |out_first_nz}, 32'd0);
      @(negedge clk); @(negedge clk);
      rst = 1'b0;
      for (int i = 0; i < 8; i++) begin
         @(negedge clk);
         if (out_valid) chk("no_result_after_rst", 32'd1, 32'd0);
      end
      accept(vecs[0], 1'b1, a);
      wait_result(a, lat, ac);
      chk("post_rst_latency", lat, 32'd5);
      @(negedge clk); @(negedge clk);
      chk("scoreboard_drained", sb.size(), 32'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL global_timeout: simulation did not complete");
      $fatal(1);
   end
endmodule

// File: doc/lza_chunk_sched.md
# lza_chunk_sched

Sequential scheduler that runs a wide negative-path LZA indicator string through a shared, narrow `DT_node_neg_rec` detection tree one chunk per cycle, MSB chunk first. It folds each chunk's tree flags into running Z/N/P/Y accumulators using the tree's own node-combine rule, so the final flags equal those of a full-width tree. It also reports the index of the first non-zero chunk, which drives coarse normalization. It sits between the operand pre-encoder, which supplies the n/z/p strings, and the normalizer or shift-count logic.

## Interface
- `DATA_WIDTH`, 32, width of the full n/z/p strings.
- `CHUNK_WIDTH`, 8, width of the shared tree. It is a power of two, at least 2, and divides `DATA_WIDTH`.
- `NUM_CHUNKS` (local), `DATA_WIDTH/CHUNK_WIDTH`. `IDX_W` (local) is `max(1, clog2(NUM_CHUNKS))`.

Ports:
- `clk`  in  1  single clock, rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `in_valid`  in  1  request valid.
- `in_ready`  out  1  controller can accept a request.
- `in_n`, `in_z`, `in_p`  in  DATA_WIDTH each  indicator strings; bit DATA_WIDTH-1 is the MSB.
- `dt_n`, `dt_z`, `dt_p`  out  CHUNK_WIDTH each  chunk presented to the shared tree.
- `dt_Z`, `dt_N`, `dt_P`, `dt_Y`  in  1 each  combinational tree response for the current `dt_*` chunk.
- `dt_active`  out  1  controller owns the tree this cycle.
- `out_valid`  out  1  result valid.
- `out_ready`  in  1  consumer accepts the result.
- `out_Z`, `out_N`, `out_P`, `out_Y`  out  1 each  full-width flags.
- `out_first_nz`  out  IDX_W  index of the first chunk (0 = MSB chunk) whose tree Z is 0.

## Operation
- The FSM has three states: IDLE, RUN and DONE.
- **IDLE:** `in_ready`=1.
  - On `in_valid`, capture `in_n/z/p` into shift registers.
  - Set the chunk counter `cnt`=0.
  - Load the accumulators with the identity Z=1, N=0, P=0, Y=0.
  - Clear `first_nz` to 0 and go to RUN.
- **RUN:**
  - `dt_active`=1.
  - `dt_*` = the top CHUNK_WIDTH bits of each shift register.
  - Each cycle, combine the accumulator (high part, h) with the tree response (low part, l):
    - Z = Zh & Zl
    - N = Zh&Nl | Nh&Zl
    - P = Ph | Zh&Pl
    - Y = Yh | Zh&Yl | Nh&Pl
  - If Zh=1 and `dt_Z`=0, latch `first_nz`=`cnt`.
  - Shift the registers left by CHUNK_WIDTH and increment `cnt`.
  - After the cycle with `cnt`=NUM_CHUNKS-1, go to DONE.
- **DONE:**
  - `out_valid`=1. The `out_*` signals come straight from the accumulator and `first_nz` registers.
  - All outputs hold stable until `out_ready`=1. On that cycle go to IDLE.
- **Tree port outside RUN:** `dt_n/z/p`=0 and `dt_active`=0. The tree's responses are ignored.
- **`in_ready` rule:** `in_ready` is 1 only in IDLE. `in_valid` in RUN or DONE is ignored and not queued.
- **All-zero string:** if every chunk has Z=1, then `out_Z`=1 and `out_first_nz`=0. Consumers must qualify `out_first_nz` with `out_Z`.
- **Counter width:** `cnt` never wraps within an operation, because it is compared against NUM_CHUNKS-1.
- **NUM_CHUNKS=1:** exactly one RUN cycle.

## Timing
- **Reset values:** asserting `rst` forces, immediately and asynchronously:
  - state = IDLE, so `in_ready`=1, including while `rst` is high.
  - `out_valid`=0, `out_Z`=`out_N`=`out_P`=`out_Y`=0, `out_first_nz`=0.
  - `dt_*`=0, `dt_active`=0.
- **Reset mid-operation:** an operation in progress is discarded with no output. The first accept is possible on the first rising edge after `rst` deasserts.
- **Latency:**
  - Accept at edge t.
  - RUN occupies cycles t+1 … t+NUM_CHUNKS.
  - `out_valid` rises after edge t+NUM_CHUNKS+1.
- **Throughput:** with `out_ready` held at 1, one result every NUM_CHUNKS+2 cycles.
- **Tree timing:** the tree is assumed purely combinational. `dt_*` come from registers, and the `dt_Z/N/P/Y` responses are sampled at the end of the same cycle.

## Test plan
Parameters: DATA_WIDTH=32, CHUNK_WIDTH=8. The shared tree is an 8-wide `DT_node_neg_rec`.

1. n=0, p=0, z=0xFFFFFFFF -> `out_valid` 5 cycles after accept; Z=1, N=0, P=0, Y=0, `first_nz`=0; `dt_active` high for exactly 4 cycles.
2. n=0x00008000, p=0, z=0xFFFF7FFF -> Z=0, N=1, P=0, Y=0, `first_nz`=2.
3. n=0, p=0x80000000, z=0x7FFFFFFF -> Z=0, N=0, P=1, Y=0, `first_nz`=0.
4. n=0x01000000, p=0x00800000, z=0xFE7FFFFF (N/P pair straddles chunks 0/1) -> Z=0, N=0, P=0, Y=1, `first_nz`=0.
5. Hold case 2's result with `out_ready`=0 for 3 cycles while pulsing `in_valid` with case 3's data -> outputs stable, `in_ready`=0, the pulse is ignored; raise `out_ready` -> IDLE next cycle; case 3 then accepted and yields P=1.
6. Assert `rst` after 2 RUN cycles of case 2 -> all outputs 0 and `in_ready`=1 during reset; no `out_valid`; case 1 run afterward returns Z=1.
